wshb_sdram_arbiter: RTL



---
 rtl/wshb_sdram_arbiter_if.sv | 26 ++
 rtl/wshb_sdram_arbiter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/wshb_sdram_arbiter_if.sv
// Wishbone bus bundle for one arbiter port.
// The master modport drives the request side; the slave modport drives the responses.
interface wshb_sdram_arbiter_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;
  logic        err;
  logic        rty;
  logic [31:0] dat_sm;

  modport master (
    output cyc, stb, we, adr, dat_ms, sel, cti, bte,
    input  ack, err, rty, dat_sm
  );

  modport slave (
    input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
    output ack, err, rty, dat_sm
  );
endinterface

// File: rtl/wshb_sdram_arbiter.sv
// Two-master round-robin Wishbone arbiter for the shared SDRAM slave port (m0 video, m1 writer).
// Define WSHB_ARB_HOLD_EN to enable forced release after HOLD_MAX owned cycles.
module wshb_sdram_arbiter #(
  parameter int unsigned HOLD_MAX = 256
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  wshb_sdram_arbiter_if.slave         m0,
  wshb_sdram_arbiter_if.slave         m1,
  wshb_sdram_arbiter_if.master        s,
  output logic [1:0]                  gnt
);

  if (HOLD_MAX < 2 || HOLD_MAX > 65535) begin : g_hold_max_range
    $error("HOLD_MAX must be in 2..65535");
  end

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StGnt0 = 2'd1,
    StGnt1 = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic       last_q, last_d;  // 0: m0 served last, 1: m1 served last
  logic [1:0] gnt_q, gnt_d;
  logic       preempt0, preempt1;

`ifdef WSHB_ARB_HOLD_EN
  localparam logic [15:0] HoldMax = 16'(HOLD_MAX);

  logic [15:0] hold_cnt_q, hold_cnt_d;
  logic        owner_resp;

  // Preempt only on a completed beat so a transfer is never split.
  always_comb begin
    owner_resp = s.ack | s.err | s.rty;
    preempt0   = (state_q == StGnt0) && (hold_cnt_q >= HoldMax) && owner_resp && m1.cyc;
    preempt1   = (state_q == StGnt1) && (hold_cnt_q >= HoldMax) && owner_resp && m0.cyc;
  end

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (state_d != state_q || state_q == StIdle) begin
      hold_cnt_d = '0;
    end else if (hold_cnt_q != 16'hffff) begin
      hold_cnt_d = hold_cnt_q + 16'd1;
    end
  end
`else
  assign preempt0 = 1'b0;
  assign preempt1 = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (m0.cyc && m1.cyc) begin
          state_d = last_q ? StGnt0 : StGnt1;
        end else if (m0.cyc) begin
          state_d = StGnt0;
        end else if (m1.cyc) begin
          state_d = StGnt1;
        end
      end
      StGnt0: begin
        if (!m0.cyc || preempt0) begin
          last_d  = 1'b0;
          state_d = m1.cyc ? StGnt1 : StIdle;
        end
      end
      StGnt1: begin
        if (!m1.cyc || preempt1) begin
          last_d  = 1'b1;
          state_d = m0.cyc ? StGnt0 : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    gnt_d = 2'b00;
    if (state_d == StGnt0) begin
      gnt_d = 2'b01;
    end else if (state_d == StGnt1) begin
      gnt_d = 2'b10;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= StIdle;
      last_q     <= 1'b1;
      gnt_q      <= 2'b00;
`ifdef WSHB_ARB_HOLD_EN
      hold_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
`ifdef WSHB_ARB_HOLD_EN
      hold_cnt_q <= hold_cnt_d;
`endif
    end
  end

  // Request/response routing; stb without cyc is illegal and masked off.
  always_comb begin
    s.cyc     = 1'b0;
    s.stb     = 1'b0;
    s.we      = 1'b0;
    s.adr     = '0;
    s.dat_ms  = '0;
    s.sel     = '0;
    s.cti     = '0;
    s.bte     = '0;
    m0.ack    = 1'b0;
    m0.err    = 1'b0;
    m0.rty    = 1'b0;
    m1.ack    = 1'b0;
    m1.err    = 1'b0;
    m1.rty    = 1'b0;
    m0.dat_sm = s.dat_sm;
    m1.dat_sm = s.dat_sm;
    if (gnt_q[0]) begin
      s.cyc    = m0.cyc;
      s.stb    = m0.cyc & m0.stb;
      s.we     = m0.we;
      s.adr    = m0.adr;
      s.dat_ms = m0.dat_ms;
      s.sel    = m0.sel;
      s.cti    = m0.cti;
      s.bte    = m0.bte;
      m0.ack   = s.ack;
      m0.err   = s.err;
      m0.rty   = s.rty;
    end else if (gnt_q[1]) begin
      s.cyc    = m1.cyc;
      s.stb    = m1.cyc & m1.stb;
      s.we     = m1.we;
      s.adr    = m1.adr;
      s.dat_ms = m1.dat_ms;
      s.sel    = m1.sel;
      s.cti    = m1.cti;
      s.bte    = m1.bte;
      m1.ack   = s.ack;
      m1.err   = s.err;
      m1.rty   = s.rty;
    end
  end

  assign gnt = gnt_q;

endmodule
